// File: rtl/multi_zone_light_ctrl.sv
// multi_zone_light_ctrl
// N-zone automatic lighting controller. Each zone runs its own small FSM
// (OFF/ON/HOLD/DIM) with one shared down-counter per zone that times both
// the HOLD and the DIM phase. Lamp enable, dim request and packed state are
// decoded straight from the state registers, so they change on the same edge
// that samples the sensor. A popcount of lit zones feeds the status display.
//
// state | meaning
// ------+-----------------------------------------------------------------
// OFF   | lamp dark; waits for motion (not in daylight) or force-on
// ON    | occupied; lamp fully lit while motion or force-on is present
// HOLD  | occupancy ended; lamp still fully lit for HOLD_CYCLES clocks
// DIM   | lamp dimmed for DIM_CYCLES clocks before going dark
module multi_zone_light_ctrl #(
    parameter int NUM_ZONES   = 4,
    parameter int HOLD_CYCLES = 200,
    parameter int DIM_CYCLES  = 50,
    parameter int TIMER_W     = 8
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [NUM_ZONES-1:0]               motion,
    input  logic [NUM_ZONES-1:0]               force_on,
    input  logic                               daylight,
    output logic [2*NUM_ZONES-1:0]             zone_state,
    output logic [NUM_ZONES-1:0]               light_on,
    output logic [NUM_ZONES-1:0]               light_dim,
    output logic [$clog2(NUM_ZONES+1)-1:0]     active_zones
);

    localparam int CNT_W = $clog2(NUM_ZONES + 1);

    // Reload values: the timer counts down to zero inclusive, so a phase of
    // N clocks starts at N-1. A zero-length DIM phase never loads the timer.
    localparam logic [TIMER_W-1:0] HOLD_LOAD = TIMER_W'(HOLD_CYCLES - 1);
    localparam logic [TIMER_W-1:0] DIM_LOAD  =
        (DIM_CYCLES > 0) ? TIMER_W'(DIM_CYCLES - 1) : '0;
    localparam bit SKIP_DIM = (DIM_CYCLES == 0);

    typedef enum logic [1:0] {
        ST_OFF  = 2'b00,
        ST_ON   = 2'b01,
        ST_HOLD = 2'b10,
        ST_DIM  = 2'b11
    } zone_state_t;

    zone_state_t          state_q [NUM_ZONES];
    zone_state_t          state_d [NUM_ZONES];
    logic [TIMER_W-1:0]   timer_q [NUM_ZONES];
    logic [TIMER_W-1:0]   timer_d [NUM_ZONES];

    // trig keeps a lit zone lit; go is the stricter condition to light a dark
    // zone, where daylight suppresses plain motion but not force-on.
    logic [NUM_ZONES-1:0] trig;
    logic [NUM_ZONES-1:0] go;

    assign trig = motion | force_on;
    assign go   = force_on | (motion & {NUM_ZONES{~daylight}});

    // State and timer registers; reset aborts any running HOLD/DIM at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_ZONES; i++) begin
                state_q[i] <= ST_OFF;
                timer_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_ZONES; i++) begin
                state_q[i] <= state_d[i];
                timer_q[i] <= timer_d[i];
            end
        end
    end

    // Next-state and timer update per zone; a retrigger beats timer expiry.
    always_comb begin
        for (int i = 0; i < NUM_ZONES; i++) begin
            state_d[i] = state_q[i];
            timer_d[i] = timer_q[i];
            case (state_q[i])
                ST_OFF: begin
                    if (go[i]) begin
                        state_d[i] = ST_ON;
                    end
                end
                ST_ON: begin
                    if (!trig[i]) begin
                        state_d[i] = ST_HOLD;
                        timer_d[i] = HOLD_LOAD;
                    end
                end
                ST_HOLD: begin
                    if (trig[i]) begin
                        state_d[i] = ST_ON;
                    end else if (timer_q[i] == '0) begin
                        if (SKIP_DIM) begin
                            state_d[i] = ST_OFF;
                        end else begin
                            state_d[i] = ST_DIM;
                            timer_d[i] = DIM_LOAD;
                        end
                    end else begin
                        timer_d[i] = timer_q[i] - TIMER_W'(1);
                    end
                end
                ST_DIM: begin
                    if (trig[i]) begin
                        state_d[i] = ST_ON;
                    end else if (timer_q[i] == '0) begin
                        state_d[i] = ST_OFF;
                    end else begin
                        timer_d[i] = timer_q[i] - TIMER_W'(1);
                    end
                end
                default: begin
                    state_d[i] = ST_OFF;
                end
            endcase
        end
    end

    // Lamp outputs decode directly from the state registers (no extra stage).
    always_comb begin
        zone_state = '0;
        light_on   = '0;
        light_dim  = '0;
        for (int i = 0; i < NUM_ZONES; i++) begin
            zone_state[2*i +: 2] = state_q[i];
            light_on[i]          = (state_q[i] != ST_OFF);
            light_dim[i]         = (state_q[i] == ST_DIM);
        end
    end

    // Popcount of lit zones; CNT_W is sized to hold NUM_ZONES exactly.
    always_comb begin
        logic [CNT_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < NUM_ZONES; i++) begin
            cnt = cnt + CNT_W'(light_on[i]);
        end
        active_zones = cnt;
    end

endmodule

// File: tb/tb_multi_zone_light_ctrl.sv
// Testbench for multi_zone_light_ctrl. Two builds share one stimulus stream:
// dut_a with HOLD=4/DIM=2 and dut_b with HOLD=4/DIM=0. A per-zone model keeps
// a "clocks since occupancy ended" count and derives the expected state from
// it; expected outputs are queued on each edge and compared at the negedge.
module tb_multi_zone_light_ctrl;

    localparam int N  = 4;
    localparam int H  = 4;
    localparam int D  = 2;
    localparam int AW = $clog2(N + 1);

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    motion;
    logic [N-1:0]    force_on;
    logic            daylight;

    logic [2*N-1:0]  zs_a, zs_b;
    logic [N-1:0]    on_a, on_b, dim_a, dim_b;
    logic [AW-1:0]   act_a, act_b;

    always #5 clk = ~clk;

    multi_zone_light_ctrl #(.NUM_ZONES(N), .HOLD_CYCLES(H), .DIM_CYCLES(D), .TIMER_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .motion(motion), .force_on(force_on), .daylight(daylight),
        .zone_state(zs_a), .light_on(on_a), .light_dim(dim_a), .active_zones(act_a)
    );

    multi_zone_light_ctrl #(.NUM_ZONES(N), .HOLD_CYCLES(H), .DIM_CYCLES(0), .TIMER_W(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .motion(motion), .force_on(force_on), .daylight(daylight),
        .zone_state(zs_b), .light_on(on_b), .light_dim(dim_b), .active_zones(act_b)
    );

    typedef struct packed {
        logic [2*N-1:0] zs_a;
        logic [N-1:0]   on_a;
        logic [N-1:0]   dim_a;
        logic [AW-1:0]  act_a;
        logic [2*N-1:0] zs_b;
        logic [N-1:0]   on_b;
        logic [N-1:0]   dim_b;
        logic [AW-1:0]  act_b;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Model: lit flag plus clocks elapsed since trig fell (0 = occupied).
    bit   lit [2][N];
    int   since [2][N];
    int   dim_len [2] = '{D, 0};

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [1:0] model_state(input int m, input int z);
        if (!lit[m][z])                    return 2'b00;
        else if (since[m][z] == 0)         return 2'b01;
        else if (since[m][z] <= H)         return 2'b10;
        else                               return 2'b11;
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++)
            for (int z = 0; z < N; z++) begin
                lit[m][z]   = 1'b0;
                since[m][z] = 0;
            end
        sb_q.delete();
    endtask

    task automatic model_edge();
        bit trig, go;
        for (int m = 0; m < 2; m++)
            for (int z = 0; z < N; z++) begin
                trig = motion[z] | force_on[z];
                go   = force_on[z] | (motion[z] & ~daylight);
                if (!lit[m][z]) begin
                    if (go) begin
                        lit[m][z]   = 1'b1;
                        since[m][z] = 0;
                    end
                end else if (trig) begin
                    since[m][z] = 0;
                end else begin
                    since[m][z]++;
                    if (since[m][z] > H + dim_len[m]) begin
                        lit[m][z]   = 1'b0;
                        since[m][z] = 0;
                    end
                end
            end
    endtask

    task automatic push_expected();
        exp_t e;
        logic [1:0] s;
        e = '0;
        for (int z = 0; z < N; z++) begin
            s = model_state(0, z);
            e.zs_a[2*z +: 2] = s;
            e.on_a[z]        = (s != 2'b00);
            e.dim_a[z]       = (s == 2'b11);
            e.act_a          = e.act_a + AW'(s != 2'b00);
            s = model_state(1, z);
            e.zs_b[2*z +: 2] = s;
            e.on_b[z]        = (s != 2'b00);
            e.dim_b[z]       = (s == 2'b11);
            e.act_b          = e.act_b + AW'(s != 2'b00);
        end
        sb_q.push_back(e);
    endtask

    task automatic compare_outputs();
        exp_t e;
        check_val("sb_depth", sb_q.size(), 1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_val("zone_state_a", zs_a, e.zs_a);
            check_val("light_on_a", on_a, e.on_a);
            check_val("light_dim_a", dim_a, e.dim_a);
            check_val("active_a", act_a, e.act_a);
            check_val("zone_state_b", zs_b, e.zs_b);
            check_val("light_on_b", on_b, e.on_b);
            check_val("light_dim_b", dim_b, e.dim_b);
            check_val("active_b", act_b, e.act_b);
        end
    endtask

    // One clock: inputs already stable; model follows the DUT edge.
    task automatic step();
        @(posedge clk);
        model_edge();
        push_expected();
        @(negedge clk);
        compare_outputs();
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_zs_a"}, zs_a, '0);
        check_val({tag, "_on_a"}, on_a, '0);
        check_val({tag, "_dim_a"}, dim_a, '0);
        check_val({tag, "_act_a"}, act_a, '0);
        check_val({tag, "_zs_b"}, zs_b, '0);
        check_val({tag, "_on_b"}, on_b, '0);
    endtask

    initial begin
        int on_cnt_a, dim_cnt_a, on_cnt_b, dim_cnt_b;

        rst_n    = 1'b0;
        motion   = '0;
        force_on = '0;
        daylight = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        step();

        // Single motion pulse in zone 0: 1 ON + 4 HOLD + 2 DIM clocks lit.
        on_cnt_a = 0; dim_cnt_a = 0; on_cnt_b = 0; dim_cnt_b = 0;
        motion = 4'b0001;
        for (int k = 0; k < 12; k++) begin
            step();
            motion = '0;
            on_cnt_a  += int'(on_a[0]);
            dim_cnt_a += int'(dim_a[0]);
            on_cnt_b  += int'(on_b[0]);
            dim_cnt_b += int'(dim_b[0]);
        end
        check_val("t2_on_len", on_cnt_a, 7);
        check_val("t2_dim_len", dim_cnt_a, 2);
        check_val("t2_final_state", zs_a[1:0], 2'b00);
        check_val("t6_on_len", on_cnt_b, 5);
        check_val("t6_dim_len", dim_cnt_b, 0);

        // Zone 1 retriggered in its second DIM clock.
        motion = 4'b0010;
        step();
        motion = '0;
        for (int k = 0; k < 6; k++) step();
        check_val("t3_in_dim", zs_a[3:2], 2'b11);
        motion = 4'b0010;
        step();
        check_val("t3_back_on", zs_a[3:2], 2'b01);
        check_val("t3_dim_clear", dim_a[1], 1'b0);
        motion = '0;
        on_cnt_a = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            on_cnt_a += int'(on_a[1]);
        end
        check_val("t3_restart_len", on_cnt_a, 6);

        // Daylight blocks motion but not force-on.
        daylight = 1'b1;
        motion   = 4'b0100;
        for (int k = 0; k < 3; k++) step();
        check_val("t4_daylight_off", on_a[2], 1'b0);
        force_on = 4'b0100;
        step();
        check_val("t4_force_on", zs_a[5:4], 2'b01);
        force_on = '0;
        for (int k = 0; k < 3; k++) step();
        check_val("t4_motion_holds", zs_a[5:4], 2'b01);
        motion = '0;
        daylight = 1'b0;
        for (int k = 0; k < 10; k++) step();

        // Three zones together, then drain.
        motion = 4'b1011;
        step();
        motion = '0;
        check_val("t5_active3", act_a, 3);
        for (int k = 0; k < 10; k++) step();
        check_val("t5_drained", act_a, 0);

        // Randomised traffic across all zones, daylight and force-on.
        for (int k = 0; k < 400; k++) begin
            motion   = N'($urandom_range(0, 15) & $urandom_range(0, 15));
            force_on = ($urandom_range(0, 15) == 0) ? N'($urandom_range(0, 15)) : '0;
            daylight = ($urandom_range(0, 3) == 0);
            step();
        end

        // Asynchronous reset mid-run: outputs clear before the next edge.
        daylight = 1'b0;
        force_on = '0;
        motion   = 4'b1111;
        step();
        motion = '0;
        step();
        step();
        check_val("t1_pre_reset_lit", act_a, 4);
        #2 rst_n = 1'b0;
        #1 check_all_zero("t1_async");
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_all_zero("t1_held");
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
